pipeline_stall_ctrl: RTL

//  Central freeze/flush sequencer for the 5-stage pipeline. Drives Freeze/Flush of the IF/ID

---
 rtl/pipeline_stall_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: central freeze/flush sequencer for the 5-stage pipeline.
// It stretches each data-memory access into a whole-pipeline stall. It resolves
// stall, branch and hazard events by fixed priority. It also keeps saturating
// statistics counters for stall and flush cycles.
//
// Ports
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   mem_req       valid load/store currently in MEM stage
//   hazard        RAW hazard from hazard detect unit
//   branch_taken  taken branch resolved in EX stage
//   clr_cnt       synchronous clear of statistics counters
//   freeze_if     hold PC and IF/ID register
//   flush_if      clear IF/ID register
//   flush_id      insert bubble into ID/EX register
//   stall_all     hold ID/EX, EX/MEM, MEM/WB registers
//   mem_done      one-cycle pulse when the memory access completes
//   stall_cnt     saturating count of freeze_if cycles
//   flush_cnt     saturating count of flush_if cycles
module pipeline_stall_ctrl #(
  parameter int unsigned MEM_CYCLES = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_req,
  input  logic             hazard,
  input  logic             branch_taken,
  input  logic             clr_cnt,
  output logic             freeze_if,
  output logic             flush_if,
  output logic             flush_id,
  output logic             stall_all,
  output logic             mem_done,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned WCNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            state;
  logic [WCNT_W-1:0] wcnt;

  logic stall_c;
  logic done_c;
  logic freeze_c;
  logic flush_if_c;
  logic flush_id_c;

  // Memory access sequencer: IDLE counts as the first stall cycle, so WAIT
  // covers the remaining MEM_CYCLES-2 stall cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      wcnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mem_req) begin
            if (MEM_CYCLES == 2) begin
              state <= S_DONE;
            end else begin
              wcnt  <= WCNT_W'(MEM_CYCLES - 2);
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (wcnt == WCNT_W'(1)) begin
            state <= S_DONE;
          end else begin
            wcnt <= wcnt - WCNT_W'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Same-cycle control decode; stall beats branch, branch beats hazard.
  always_comb begin
    stall_c    = 1'b0;
    done_c     = 1'b0;
    freeze_c   = 1'b0;
    flush_if_c = 1'b0;
    flush_id_c = 1'b0;

    case (state)
      S_IDLE:  stall_c = mem_req;
      S_WAIT:  stall_c = 1'b1;
      S_DONE:  done_c  = 1'b1;
      default: stall_c = 1'b0;
    endcase

    if (stall_c) begin
      freeze_c = 1'b1;
    end else if (branch_taken) begin
      flush_if_c = 1'b1;
      flush_id_c = 1'b1;
    end else if (hazard) begin
      freeze_c   = 1'b1;
      flush_id_c = 1'b1;
    end
  end

  // Outputs are forced low for the whole time reset is held.
  assign stall_all = stall_c    & ~rst;
  assign mem_done  = done_c     & ~rst;
  assign freeze_if = freeze_c   & ~rst;
  assign flush_if  = flush_if_c & ~rst;
  assign flush_id  = flush_id_c & ~rst;

  // Saturating statistics; clear takes precedence over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (clr_cnt) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (freeze_if && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_if  && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
